pulse_blinker: RTL and testbench

PULSE_BLINKER -- requirements
Module: pulse_blinker

---
 rtl/blackjack_pkg.sv | 16 +
 rtl/sat_updown_counter.sv | 44 ++++
 rtl/pulse_blinker.sv | 123 ++++++++++++
 tb/tb_pulse_blinker.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/blackjack_pkg.sv
// Shared definitions for the game-board peripherals: blinker state encoding and helpers.
// No logic of its own; elaboration-time only.
// No flow control.
package blackjack_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } blink_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sat_updown_counter.sv
// Saturating up/down counter with synchronous clear; holds blinks queued behind the active one.
// Count visible one cycle after inc/dec/clr.
// inc at MAX and dec at zero are ignored; inc with dec together leaves the count unchanged.
module sat_updown_counter #(
    parameter int MAX = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       inc_i,
    input  logic                       dec_i,
    input  logic                       clr_i,
    output logic [$clog2(MAX+1)-1:0]   count_o,
    output logic                       sat_o
);

    localparam int W = $clog2(MAX + 1);
    localparam logic [W-1:0] MAX_CNT = W'(MAX);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && !dec_i && (count_q != MAX_CNT)) begin
            count_d = count_q + W'(1);
        end else if (dec_i && !inc_i && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign sat_o   = (count_q == MAX_CNT);

endmodule

// File: rtl/pulse_blinker.sv
// Stretches trigger strobes into ON_CYCLES-high blinks separated by OFF_CYCLES gaps, queuing extras.
// Latency 1: blink rises the cycle after a trigger seen in IDLE.
// Triggers beyond MAX_PENDING queued are dropped with a one-cycle overflow pulse; clr flushes all.
module pulse_blinker
    import blackjack_pkg::*;
#(
    parameter int ON_CYCLES   = 3,
    parameter int OFF_CYCLES  = 2,
    parameter int MAX_PENDING = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               trig,
    input  logic                               clr,
    output logic                               blink,
    output logic                               busy,
    output logic [$clog2(MAX_PENDING+1)-1:0]   pending,
    output logic                               overflow
);

    localparam int PW = $clog2(MAX_PENDING + 1);
    localparam int CW = $clog2(max_int(ON_CYCLES, OFF_CYCLES) + 1);
    localparam logic [CW-1:0] ON_LOAD  = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] OFF_LOAD = CW'(OFF_CYCLES - 1);

    blink_state_e  state_q;
    logic [CW-1:0] cnt_q;
    logic          blink_q;
    logic          busy_q;
    logic          ovf_q;

    logic          active;
    logic          last_gap;
    logic          q_empty;
    logic          q_full;
    logic          q_inc;
    logic          q_dec;
    logic          ovf_d;
    logic [PW-1:0] q_cnt;

    assign active   = (state_q != ST_IDLE);
    assign last_gap = (state_q == ST_GAP) && (cnt_q == '0);
    assign q_empty  = (q_cnt == '0);

    // On the last gap cycle an empty queue lets the trigger start the next blink directly.
    assign q_inc = trig && active && !(last_gap && q_empty);
    assign q_dec = last_gap && !q_empty;
    assign ovf_d = trig && active && !last_gap && q_full;

    sat_updown_counter #(
        .MAX (MAX_PENDING)
    ) u_pending (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (q_inc),
        .dec_i   (q_dec),
        .clr_i   (clr),
        .count_o (q_cnt),
        .sat_o   (q_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            blink_q <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (clr) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            blink_q <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            case (state_q)
                ST_IDLE: begin
                    if (trig) begin
                        state_q <= ST_ON;
                        cnt_q   <= ON_LOAD;
                        blink_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ST_ON: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_GAP;
                        cnt_q   <= OFF_LOAD;
                        blink_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else if (!q_empty || trig) begin
                        state_q <= ST_ON;
                        cnt_q   <= ON_LOAD;
                        blink_q <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    blink_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign blink    = blink_q;
    assign busy     = busy_q;
    assign pending  = q_cnt;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_pulse_blinker.sv
// Directed bench for pulse_blinker with a period-countdown reference model checked every cycle.
// Literal expectations pin the blink timing, queueing, clear and reset behaviour.
module tb_pulse_blinker;

    localparam int ON   = 3;
    localparam int OFF  = 2;
    localparam int MAXP = 2;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       trig  = 1'b0;
    logic       clr   = 1'b0;
    logic       blink;
    logic       busy;
    logic [1:0] pending;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    pulse_blinker #(
        .ON_CYCLES   (ON),
        .OFF_CYCLES  (OFF),
        .MAX_PENDING (MAXP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .trig     (trig),
        .clr      (clr),
        .blink    (blink),
        .busy     (busy),
        .pending  (pending),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Model: m_left = cycles remaining in the current ON+OFF period (0 = idle), m_q = queued blinks.
    int m_left = 0;
    int m_q    = 0;
    bit m_ovf  = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            m_q    <= 0;
            m_ovf  <= 1'b0;
        end else if (clr) begin
            m_left <= 0;
            m_q    <= 0;
            m_ovf  <= 1'b0;
        end else begin
            m_ovf <= 1'b0;
            if (m_left == 0) begin
                if (trig) m_left <= ON + OFF;
            end else if (m_left == 1) begin
                if (m_q > 0) begin
                    m_left <= ON + OFF;
                    m_q    <= m_q - 1 + (trig ? 1 : 0);
                end else if (trig) begin
                    m_left <= ON + OFF;
                end else begin
                    m_left <= 0;
                end
            end else begin
                m_left <= m_left - 1;
                if (trig) begin
                    if (m_q < MAXP) m_q <= m_q + 1;
                    else            m_ovf <= 1'b1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    bit mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            chk("model_blink",    8'(blink),    8'(m_left > OFF));
            chk("model_busy",     8'(busy),     8'(m_left > 0));
            chk("model_pending",  8'(pending),  8'(m_q));
            chk("model_overflow", 8'(overflow), 8'(m_ovf));
        end
    end

    logic       bl [0:63];
    logic       bz [0:63];
    logic       ov [0:63];
    logic [1:0] pd [0:63];

    // Drives cycle k with tm[k]/cm[k]; index k+1 holds the outputs seen in the following cycle.
    task automatic run(input logic [63:0] tm, input logic [63:0] cm, input int n);
        bl[0] = blink; bz[0] = busy; pd[0] = pending; ov[0] = overflow;
        for (int k = 0; k < n; k++) begin
            trig = tm[k];
            clr  = cm[k];
            @(posedge clk);
            #1;
            bl[k+1] = blink;
            bz[k+1] = busy;
            pd[k+1] = pending;
            ov[k+1] = overflow;
        end
        trig = 1'b0;
        clr  = 1'b0;
    endtask

    initial begin
        int rises;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_blink",    8'(blink),    8'd0);
        chk("reset_busy",     8'(busy),     8'd0);
        chk("reset_pending",  8'(pending),  8'd0);
        chk("reset_overflow", 8'(overflow), 8'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Single trigger: high 1-3, gap 4-5, idle at 6.
        run(64'h1, 64'h0, 8);
        for (int c = 1; c <= 7; c++) begin
            chk("single_blink", 8'(bl[c]), 8'(c <= 3));
            chk("single_busy",  8'(bz[c]), 8'(c <= 5));
        end

        // Four back-to-back triggers: two queued, one dropped.
        run(64'hF, 64'h0, 18);
        chk("burst_pending_c2", 8'(pd[2]), 8'd1);
        chk("burst_pending_c3", 8'(pd[3]), 8'd2);
        rises = 0;
        for (int c = 1; c <= 17; c++) begin
            chk("burst_overflow", 8'(ov[c]), 8'(c == 4));
            if (bl[c] && !bl[c-1]) rises++;
        end
        chk("burst_blinks",    8'(rises), 8'd3);
        chk("burst_busy_c15",  8'(bz[15]), 8'd1);
        chk("burst_idle_c16",  8'(bz[16]), 8'd0);

        // Trigger on last gap cycle with empty queue starts the next blink directly.
        run(64'h21, 64'h0, 12);
        for (int c = 1; c <= 11; c++) begin
            chk("lastgap_blink",   8'(bl[c]), 8'((c >= 1 && c <= 3) || (c >= 6 && c <= 8)));
            chk("lastgap_pending", 8'(pd[c]), 8'd0);
        end
        chk("lastgap_idle", 8'(bz[11]), 8'd0);

        // Clear with a coincident trigger while one blink is queued.
        run(64'h7, 64'h4, 10);
        chk("clr_pending_c2", 8'(pd[2]), 8'd1);
        chk("clr_busy_c3",    8'(bz[3]), 8'd0);
        chk("clr_pending_c3", 8'(pd[3]), 8'd0);
        for (int c = 3; c <= 10; c++) begin
            chk("clr_blink",    8'(bl[c]), 8'd0);
            chk("clr_overflow", 8'(ov[c]), 8'd0);
        end

        // Held trigger counts every cycle; full queue plus trigger on the last gap cycle.
        run(64'hFFFFF, 64'h0, 24);
        chk("held_overflow_c4", 8'(ov[4]), 8'd1);
        chk("held_pending_c6",  8'(pd[6]), 8'd2);
        run(64'h0, 64'h0, 18);
        chk("held_drained", 8'(bz[18]), 8'd0);

        // Asynchronous reset in the middle of an ON period.
        run(64'h3, 64'h0, 2);
        chk("pre_rst_blink", 8'(blink), 8'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_blink",    8'(blink),    8'd0);
        chk("async_rst_busy",     8'(busy),     8'd0);
        chk("async_rst_pending",  8'(pending),  8'd0);
        chk("async_rst_overflow", 8'(overflow), 8'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // trig together with clr from IDLE does nothing.
        run(64'h1, 64'h1, 4);
        for (int c = 1; c <= 4; c++) begin
            chk("trigclr_blink",    8'(bl[c]), 8'd0);
            chk("trigclr_overflow", 8'(ov[c]), 8'd0);
            chk("trigclr_busy",     8'(bz[c]), 8'd0);
        end

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
